// File: rtl/arcade_input_ctrl.sv
// Purpose : conditions PS/2 key events and two joysticks into the game core's active-low controls.
// Latency : joystick/pause_clr -> output 1 cycle; PS/2 event -> key state 1 cycle -> output 2 cycles.
// Backpress: none; all inputs are sampled levels, outputs are always valid.
//
// Ports:
//   clk, rst_n     : 24 MHz clock, asynchronous active-low reset
//   ps2_key[10:0]  : [10] event toggle, [9] pressed, [8] extended (ignored), [7:0] scan code
//   joy_0, joy_1   : active-high joysticks, [0]R [1]L [2]D [3]U [4]fire [5]bomb
//                    [6]start1 [7]start2 [8]coin [9]pause
//   pause_clr      : synchronous clear of the pause toggle
//   start_button   : active-low {start2,start1}
//   coin_input     : active-low {coin2,coin1}, each a COIN_PULSE-cycle pulse
//   joystick1/2    : active-low {bomb,fire,up,down,left,right}
//   pause_n, test_n: active-low pause and service/test
//
// Optional build macro AUTOFIRE_EN: gates each player's fire with a free-running
// phase toggling every AUTOFIRE_DIV cycles while fire is held.

module arcade_input_ctrl #(
  parameter int COIN_PULSE   = 2400000,
  parameter int AUTOFIRE_DIV = 1200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy_0,
  input  logic [15:0] joy_1,
  input  logic        pause_clr,
  output logic [1:0]  start_button,
  output logic [1:0]  coin_input,
  output logic [5:0]  joystick1,
  output logic [5:0]  joystick2,
  output logic        pause_n,
  output logic        test_n
);

  localparam int            CW        = $clog2(COIN_PULSE + 1);
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_PULSE);

  // Bit order of the per-player vectors matches both the joystick input bits
  // and the output bus: [5]bomb [4]fire [3]up [2]down [1]left [0]right.
  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;
  localparam int B_FIRE  = 4;
  localparam int B_BOMB  = 5;

  // PS/2 event detection
  logic prev_tog_q, prev_tog_d;
  logic armed_q, armed_d;
  logic ps2_evt;

  // Key state
  logic [5:0] key_p1_q, key_p1_d;
  logic [5:0] key_p2_q, key_p2_d;
  logic [1:0] key_start_q, key_start_d;
  logic [1:0] key_coin_q, key_coin_d;
  logic       key_pause_q, key_pause_d;
  logic       key_test_q, key_test_d;

  // Merged requests
  logic [5:0] p1_req, p2_req;
  logic [1:0] start_req;
  logic [1:0] coin_req;
  logic       pause_req;
  logic [1:0] fire_req;
  logic [1:0] fire_gated;
  logic [5:0] p1_out, p2_out;

  // Coin stretchers
  logic [1:0]         coin_req_prev_q, coin_req_prev_d;
  logic [1:0][CW-1:0] coin_cnt_q, coin_cnt_d;
  logic [1:0]         coin_active;

  // Pause toggle
  logic pause_req_prev_q, pause_req_prev_d;
  logic pause_q, pause_d;
  logic pause_edge;

  // Registered outputs
  logic [1:0] start_button_q, start_button_d;
  logic [1:0] coin_input_q, coin_input_d;
  logic [5:0] joystick1_q, joystick1_d;
  logic [5:0] joystick2_q, joystick2_d;
  logic       pause_n_q, pause_n_d;
  logic       test_n_q, test_n_d;

  // Extended-key flag and upper joystick bits carry nothing for this core.
  logic unused_bits;
  assign unused_bits = ^{ps2_key[8], joy_0[15:10], joy_1[15:10]};

`ifdef AUTOFIRE_EN
  localparam int            AW      = $clog2(AUTOFIRE_DIV + 1);
  localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_DIV - 1);

  logic [1:0]         af_phase_q, af_phase_d;
  logic [1:0][AW-1:0] af_cnt_q, af_cnt_d;
`else
  localparam int unused_af_div = AUTOFIRE_DIV;
`endif

  //--------------------------------------------------------------------------
  // PS/2 decode
  //--------------------------------------------------------------------------
  always_comb begin
    // The first cycle out of reset only captures the toggle level, so a stale
    // toggle left over from before reset never registers as an event.
    ps2_evt     = armed_q && (ps2_key[10] != prev_tog_q);
    prev_tog_d  = ps2_key[10];
    armed_d     = 1'b1;

    key_p1_d    = key_p1_q;
    key_p2_d    = key_p2_q;
    key_start_d = key_start_q;
    key_coin_d  = key_coin_q;
    key_pause_d = key_pause_q;
    key_test_d  = key_test_q;

    if (ps2_evt) begin
      case (ps2_key[7:0])
        8'h75:        key_p1_d[B_UP]    = ps2_key[9];
        8'h72:        key_p1_d[B_DOWN]  = ps2_key[9];
        8'h6B:        key_p1_d[B_LEFT]  = ps2_key[9];
        8'h74:        key_p1_d[B_RIGHT] = ps2_key[9];
        8'h14, 8'h11: key_p1_d[B_FIRE]  = ps2_key[9];
        8'h29:        key_p1_d[B_BOMB]  = ps2_key[9];
        8'h1D:        key_p2_d[B_UP]    = ps2_key[9];
        8'h1B:        key_p2_d[B_DOWN]  = ps2_key[9];
        8'h1C:        key_p2_d[B_LEFT]  = ps2_key[9];
        8'h23:        key_p2_d[B_RIGHT] = ps2_key[9];
        8'h15:        key_p2_d[B_FIRE]  = ps2_key[9];
        8'h24:        key_p2_d[B_BOMB]  = ps2_key[9];
        8'h05:        key_start_d[0]    = ps2_key[9];
        8'h06:        key_start_d[1]    = ps2_key[9];
        8'h04:        key_coin_d[0]     = ps2_key[9];
        8'h0B:        key_coin_d[1]     = ps2_key[9];
        8'h0C:        key_pause_d       = ps2_key[9];
        8'h03:        key_test_d        = ps2_key[9];
        default: ;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Request merge, coin stretchers, autofire, pause, output staging
  //--------------------------------------------------------------------------
  always_comb begin
    // Each player's controls come only from its own key set and joystick;
    // start is shared between both joysticks.
    p1_req    = key_p1_q | joy_0[5:0];
    p2_req    = key_p2_q | joy_1[5:0];
    start_req = key_start_q | {joy_0[7] | joy_1[7], joy_0[6] | joy_1[6]};
    coin_req  = key_coin_q | {joy_1[8], joy_0[8]};
    pause_req = key_pause_q | joy_0[9] | joy_1[9];
    fire_req  = {p2_req[B_FIRE], p1_req[B_FIRE]};

    // Counter is loaded on an edge seen while idle and counts down to zero.
    // The output flop samples "counter next != 0", so the pulse starts the
    // cycle after the edge and lasts exactly COIN_PULSE cycles.
    coin_req_prev_d = coin_req;
    coin_cnt_d      = coin_cnt_q;
    coin_active     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (coin_cnt_q[i] == '0) begin
        if (coin_req[i] && !coin_req_prev_q[i]) begin
          coin_cnt_d[i] = COIN_LOAD;
        end
      end else begin
        coin_cnt_d[i] = coin_cnt_q[i] - CW'(1);
      end
      coin_active[i] = (coin_cnt_d[i] != '0);
    end

`ifdef AUTOFIRE_EN
    // Phase starts high so a fresh press fires immediately, then flips every
    // AUTOFIRE_DIV cycles while held; release rearms it.
    af_phase_d = af_phase_q;
    af_cnt_d   = af_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (fire_req[i]) begin
        if (af_cnt_q[i] == AF_LAST) begin
          af_cnt_d[i]   = '0;
          af_phase_d[i] = ~af_phase_q[i];
        end else begin
          af_cnt_d[i] = af_cnt_q[i] + AW'(1);
        end
      end else begin
        af_cnt_d[i]   = '0;
        af_phase_d[i] = 1'b1;
      end
    end
    fire_gated = fire_req & af_phase_q;
`else
    fire_gated = fire_req;
`endif

    p1_out = {p1_req[B_BOMB], fire_gated[0], p1_req[B_UP:B_RIGHT]};
    p2_out = {p2_req[B_BOMB], fire_gated[1], p2_req[B_UP:B_RIGHT]};

    // Clear has priority over a toggle edge in the same cycle.
    pause_req_prev_d = pause_req;
    pause_edge       = pause_req && !pause_req_prev_q;
    if (pause_clr) begin
      pause_d = 1'b0;
    end else begin
      pause_d = pause_q ^ pause_edge;
    end

    start_button_d = ~start_req;
    coin_input_d   = ~coin_active;
    joystick1_d    = ~p1_out;
    joystick2_d    = ~p2_out;
    pause_n_d      = ~pause_d;
    test_n_d       = ~key_test_q;
  end

  //--------------------------------------------------------------------------
  // State
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_tog_q       <= 1'b0;
      armed_q          <= 1'b0;
      key_p1_q         <= '0;
      key_p2_q         <= '0;
      key_start_q      <= '0;
      key_coin_q       <= '0;
      key_pause_q      <= 1'b0;
      key_test_q       <= 1'b0;
      coin_req_prev_q  <= '0;
      coin_cnt_q       <= '0;
      pause_req_prev_q <= 1'b0;
      pause_q          <= 1'b0;
      start_button_q   <= 2'b11;
      coin_input_q     <= 2'b11;
      joystick1_q      <= 6'h3F;
      joystick2_q      <= 6'h3F;
      pause_n_q        <= 1'b1;
      test_n_q         <= 1'b1;
    end else begin
      prev_tog_q       <= prev_tog_d;
      armed_q          <= armed_d;
      key_p1_q         <= key_p1_d;
      key_p2_q         <= key_p2_d;
      key_start_q      <= key_start_d;
      key_coin_q       <= key_coin_d;
      key_pause_q      <= key_pause_d;
      key_test_q       <= key_test_d;
      coin_req_prev_q  <= coin_req_prev_d;
      coin_cnt_q       <= coin_cnt_d;
      pause_req_prev_q <= pause_req_prev_d;
      pause_q          <= pause_d;
      start_button_q   <= start_button_d;
      coin_input_q     <= coin_input_d;
      joystick1_q      <= joystick1_d;
      joystick2_q      <= joystick2_d;
      pause_n_q        <= pause_n_d;
      test_n_q         <= test_n_d;
    end
  end

`ifdef AUTOFIRE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_phase_q <= 2'b11;
      af_cnt_q   <= '0;
    end else begin
      af_phase_q <= af_phase_d;
      af_cnt_q   <= af_cnt_d;
    end
  end
`endif

  assign start_button = start_button_q;
  assign coin_input   = coin_input_q;
  assign joystick1    = joystick1_q;
  assign joystick2    = joystick2_q;
  assign pause_n      = pause_n_q;
  assign test_n       = test_n_q;

endmodule

// File: doc/arcade_input_ctrl.md
Name: arcade_input_ctrl

Overview:
Input conditioning stage between the HPS I/O block (PS/2 key events, two MiSTer joysticks) and the game core's active-low control inputs.
- Decodes PS/2 make/break events into per-player key state and merges it with the joysticks.
- Stretches coin requests into fixed-width pulses.
- Keeps the pause toggle and outputs everything registered and in game polarity.

Parameters:
COIN_PULSE, 2400000, coin output width in clk cycles (100 ms at 24 MHz); minimum 1
AUTOFIRE_DIV, 1200000, autofire half-period in clk cycles (used only with AUTOFIRE_EN)

Ports:
clk  in  1  system clock (24 MHz)
rst_n  in  1  asynchronous active-low reset
ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended (ignored), [7:0] scan code
joy_0  in  16  player 1 joystick, active-high: [0]R [1]L [2]D [3]U [4]fire [5]bomb [6]start1 [7]start2 [8]coin [9]pause
joy_1  in  16  player 2 joystick, same bit map
pause_clr  in  1  synchronous clear of the pause state (OSD reset)
start_button  out  2  active-low {start2,start1}
coin_input  out  2  active-low {coin2,coin1}
joystick1  out  6  active-low {bomb,fire,up,down,left,right}, player 1
joystick2  out  6  active-low, player 2, same order
pause_n  out  1  active-low pause to game
test_n  out  1  active-low service/test

Behaviour:
Reset state:
- All outputs deasserted, i.e. driven high: start_button=2'b11, coin_input=2'b11, joystick1/2=6'h3F, pause_n=1, test_n=1.
- Key states, pause, coin counters and edge registers cleared to 0.
- armed=0.

PS/2 event detection:
- First clock after reset: prev_tog <= ps2_key[10], armed <= 1, no event.
- Afterwards an event is ps2_key[10] != prev_tog while armed; prev_tog follows every cycle.

Key map (key state <= ps2_key[9] on event; unlisted codes ignored):
- P1: 75 up, 72 down, 6B left, 74 right, 14 fire, 11 fire, 29 bomb.
- P2: 1D up, 1B down, 1C left, 23 right, 15 fire, 24 bomb.
- System: 05 start1, 06 start2, 04 coin1, 0B coin2, 0C pause, 03 test.

Request terms:
- Player request = key | own joystick bit. No cross-player OR.
- start1/start2 = respective keys | joy_0[6]|joy_1[6] and joy_0[7]|joy_1[7].
- coin1 request = F3 | joy_0[8]; coin2 request = F6 | joy_1[8].

Output timing:
- Outputs are registered inverted requests.
- Joystick change at cycle N appears at N+1.
- PS/2 event at cycle N updates key state at N+1 and the output at N+2.

Coin stretcher (per coin, independent):
- A rising edge of the request while idle loads the counter. Output is asserted for exactly COIN_PULSE cycles starting the cycle after the edge.
- Edges during an active pulse are ignored.
- A held request does not retrigger; a new rising edge is required after the pulse ends.

Pause:
- A rising edge of (F4 | joy_0[9] | joy_1[9]) toggles pause. pause_n = ~pause.
- pause_clr forces pause=0 and wins over a simultaneous edge.

test_n = ~test key.

rst_n deassertion mid-pulse or with keys held:
- All state clears.
- Held PS/2 keys stay released until their next make event.

Optional Feature:
AUTOFIRE_EN
- Defined: each player's fire output is gated by a per-player phase flip-flop and counter.
- While fire is requested, fire is asserted on the first cycle (phase=1) and toggles every AUTOFIRE_DIV cycles.
- Release resets the counter and sets phase=1.
- Bomb is unaffected.
- Undefined: fire passes straight through; no counters are synthesized.

Test Plan:
1. Reset with ps2_key[10]=1, release rst_n, hold 4 cycles -> no event; all outputs high (joystick1=6'h3F).
2. Toggle ps2_key[10] with [9]=1, code 75; later toggle again with [9]=0 -> joystick1[3]=0 two cycles after the first toggle; back to 1 two cycles after the second.
3. COIN_PULSE=8: hold joy_0[8] high for 20 cycles -> coin_input[0]=0 for exactly 8 cycles, then high while still held. Pulse joy_0[8] again 3 cycles into a new pulse -> that pulse stays 8 cycles.
4. joy_1[9] rising edge twice -> pause_n goes 0, then 1. Assert pause_clr on the same cycle as a third edge -> pause_n stays 1.
5. P2 code 1C make, with joy_0[1]=1 -> joystick2[1]=0 and joystick1[1]=0, each from its own source only. Release code 1C -> joystick2[1]=1 and joystick1[1] stays 0.
6. AUTOFIRE_EN, AUTOFIRE_DIV=4: hold joy_0[4] -> joystick1[4] pattern 0000111100001111…; release and re-press -> restarts at 0.
